edp_mpy_seq: RTL and testbench

//  Microsequencer that drives the EDP control lines for a signed Booth radix-2 multiply.
//  Per step it runs an AD add/sub/pass phase, then a shift phase (AR/ARX via SHM, MQ via
//  MQ SHR); the product ends in AR,ARX. Sits in EBOX beside CTL; its outputs override
//  the CTL_* select/load lines while busy.

---
 rtl/edp_seq_pkg.sv | 69 ++++++
 rtl/edp_step_ctr.sv | 34 +++
 rtl/edp_mpy_seq.sv | 136 +++++++++++++
 tb/tb_edp_mpy_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edp_seq_pkg.sv
// Shared EDP sequencer types: state encodings, AD ops, select codes
// and the registered control bundle driven onto the EDP lines.
package edp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ADDPH,
    S_SHPH,
    S_DONE
  } tMpyState;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } tAdOp;

  localparam logic [2:0] SEL_AD = 3'b010;
  localparam logic [2:0] SEL_SH = 3'b100;

  typedef enum logic [1:0] {
    usrLOAD = 2'd0,
    usrSHL  = 2'd1,
    usrSHR  = 2'd2,
    usrHOLD = 2'd3
  } tUSRfunc;

  typedef struct packed {
    logic       busy;
    logic       done;
    tAdOp       ad_op;
    logic [2:0] ar_sel;
    logic [2:0] arx_sel;
    logic       ar_load;
    logic       arx_load;
    logic       arx_clr;
    tUSRfunc    mq_sel;
    logic [5:0] sh_count;
  } tMpyCtl;

  localparam tMpyCtl CTL_IDLE = '{
    busy:     1'b0,
    done:     1'b0,
    ad_op:    PASS,
    ar_sel:   SEL_AD,
    arx_sel:  SEL_AD,
    ar_load:  1'b0,
    arx_load: 1'b0,
    arx_clr:  1'b0,
    mq_sel:   usrHOLD,
    sh_count: 6'd0
  };

  // Booth radix-2 recoding of {current LSB, previous LSB}
  function automatic tAdOp booth_op(
    input logic cur,
    input logic prev
  );
    tAdOp op;
    case ({cur, prev})
      2'b10:   op = SUB;
      2'b01:   op = ADD;
      default: op = PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/edp_step_ctr.sv
// Loadable step down-counter; load saturates at MAX and the
// decrement stops at zero so the count never wraps.
module edp_step_ctr
  import edp_seq_pkg::*;
#(
  parameter int W   = 6,
  parameter int MAX = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         one
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > MAXV) ? MAXV : load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/edp_mpy_seq.sv
// Booth radix-2 multiply microsequencer: alternates an AD phase and
// an AR/ARX/MQ shift phase per multiplier bit, product in AR,ARX.
module edp_mpy_seq
  import edp_seq_pkg::*;
#(
  parameter int STEP_W    = 6,
  parameter int MAX_STEPS = 36
) (
  input  logic              eboxClk,
  input  logic              eboxReset,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              abort,
  input  logic              mq35,
  output logic              busy,
  output logic              done,
  output logic [1:0]        adOp,
  output logic [2:0]        arSel,
  output logic [2:0]        arxSel,
  output logic              arLoad,
  output logic              arxLoad,
  output logic              arxClr,
  output logic [1:0]        mqSel,
  output logic [5:0]        shCount,
  output logic [STEP_W-1:0] stepsLeft
);

  tMpyState state;
  tMpyState state_nxt;
  tMpyCtl   ctl_q;
  tMpyCtl   ctl_d;
  logic     mq_prev;
  logic     mq_prev_d;
  logic     ctr_load;
  logic     ctr_dec;
  logic     cnt_zero;
  logic     cnt_one;

  logic [STEP_W-1:0] cnt;

  edp_step_ctr #(
    .W   (STEP_W),
    .MAX (MAX_STEPS)
  ) u_ctr (
    .clk      (eboxClk),
    .rst      (eboxReset),
    .load     (ctr_load),
    .load_val (steps),
    .dec      (ctr_dec),
    .count    (cnt),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state   <= S_IDLE;
      ctl_q   <= CTL_IDLE;
      mq_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctl_q   <= ctl_d;
      mq_prev <= mq_prev_d;
    end
  end

  always_comb begin
    state_nxt = state;
    ctl_d     = CTL_IDLE;
    mq_prev_d = mq_prev;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    // abort outranks everything, including start in IDLE
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_INIT;
            ctr_load  = 1'b1;
            mq_prev_d = 1'b0;
          end
        end
        S_INIT: begin
          ctl_d.busy    = 1'b1;
          ctl_d.arx_clr = 1'b1;
          ctl_d.mq_sel  = usrHOLD;
          state_nxt     = cnt_zero ? S_DONE : S_ADDPH;
        end
        S_ADDPH: begin
          ctl_d.busy    = 1'b1;
          ctl_d.ad_op   = booth_op(mq35, mq_prev);
          ctl_d.ar_sel  = SEL_AD;
          ctl_d.ar_load = 1'b1;
          ctl_d.mq_sel  = usrHOLD;
          state_nxt     = S_SHPH;
        end
        S_SHPH: begin
          ctl_d.busy     = 1'b1;
          ctl_d.ar_sel   = SEL_SH;
          ctl_d.arx_sel  = SEL_SH;
          ctl_d.sh_count = 6'd1;
          ctl_d.ar_load  = 1'b1;
          ctl_d.arx_load = 1'b1;
          ctl_d.mq_sel   = usrSHR;
          mq_prev_d      = mq35;
          ctr_dec        = 1'b1;
          state_nxt      = cnt_one ? S_DONE : S_ADDPH;
        end
        S_DONE: begin
          ctl_d.done = 1'b1;
          state_nxt  = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign busy      = ctl_q.busy;
  assign done      = ctl_q.done;
  assign adOp      = ctl_q.ad_op;
  assign arSel     = ctl_q.ar_sel;
  assign arxSel    = ctl_q.arx_sel;
  assign shCount   = ctl_q.sh_count;
  assign stepsLeft = cnt;

  // abort must kill register writes in the very cycle it arrives
  assign arLoad  = ctl_q.ar_load & ~abort;
  assign arxLoad = ctl_q.arx_load & ~abort;
  assign arxClr  = ctl_q.arx_clr & ~abort;
  assign mqSel   = abort ? usrHOLD : ctl_q.mq_sel;

endmodule

// File: tb/tb_edp_mpy_seq.sv
// Directed bench for edp_mpy_seq, including a small EDP register
// model that checks a full 36-step Booth product.
module tb_edp_mpy_seq;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] MQ_SHR  = 2'd2;
  localparam logic [1:0] MQ_HOLD = 2'd3;
  localparam logic [2:0] S_AD    = 3'b010;
  localparam logic [2:0] S_SH    = 3'b100;

  logic       eboxClk = 1'b0;
  logic       eboxReset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] steps = 6'd0;
  logic       abort = 1'b0;
  logic       mq35 = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] adOp;
  logic [2:0] arSel;
  logic [2:0] arxSel;
  logic       arLoad;
  logic       arxLoad;
  logic       arxClr;
  logic [1:0] mqSel;
  logic [5:0] shCount;
  logic [5:0] stepsLeft;

  int tests = 0;
  int fails = 0;

  edp_mpy_seq dut (
    .eboxClk   (eboxClk),
    .eboxReset (eboxReset),
    .start     (start),
    .steps     (steps),
    .abort     (abort),
    .mq35      (mq35),
    .busy      (busy),
    .done      (done),
    .adOp      (adOp),
    .arSel     (arSel),
    .arxSel    (arxSel),
    .arLoad    (arLoad),
    .arxLoad   (arxLoad),
    .arxClr    (arxClr),
    .mqSel     (mqSel),
    .shCount   (shCount),
    .stepsLeft (stepsLeft)
  );

  always #5 eboxClk = ~eboxClk;

  task automatic tick;
    @(posedge eboxClk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    eboxReset = 1'b1;
    tick();
    tick();
    eboxReset = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests++;
    if ({done, arLoad, arxLoad, arxClr} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes: got %b want 0000",
               {done, arLoad, arxLoad, arxClr});
    end
    tests++;
    if (adOp !== OP_PASS || mqSel !== MQ_HOLD) begin
      fails++;
      $display("FAIL reset_ops: got adOp=%0d mqSel=%0d want 0/3",
               adOp, mqSel);
    end
    tests++;
    if (shCount !== 6'd0 || stepsLeft !== 6'd0) begin
      fails++;
      $display("FAIL reset_counts: got sh=%0d left=%0d want 0/0",
               shCount, stepsLeft);
    end
  endtask

  task automatic test_reset_mid;
    steps = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    eboxReset = 1'b1;
    tick();
    eboxReset = 1'b0;
    tests++;
    if (busy !== 1'b0 || arLoad !== 1'b0) begin
      fails++;
      $display("FAIL midreset_busy_load: got %b%b want 00", busy, arLoad);
    end
    tests++;
    if (mqSel !== MQ_HOLD || stepsLeft !== 6'd0) begin
      fails++;
      $display("FAIL midreset_mq_left: got mqSel=%0d left=%0d want 3/0",
               mqSel, stepsLeft);
    end
    idle(3);
  endtask

  task automatic test_booth_ops;
    logic       bits [4];
    logic [1:0] ops  [4];
    int         done_at;
    int         dones;
    bits    = '{1'b1, 1'b0, 1'b1, 1'b1};
    ops     = '{OP_SUB, OP_ADD, OP_SUB, OP_PASS};
    done_at = -1;
    dones   = 0;
    steps   = 6'd4;
    start   = 1'b1;
    mq35    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 8) mq35 = bits[(c - 1) / 2];
      if (c % 2 == 0 && c <= 8) begin
        tests++;
        if (adOp !== ops[c / 2 - 1]) begin
          fails++;
          $display("FAIL booth_op_step%0d: got %0d want %0d",
                   c / 2, adOp, ops[c / 2 - 1]);
        end
      end
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
    tests++;
    if (done_at !== 10 || dones !== 1) begin
      fails++;
      $display("FAIL booth_done: got cycle=%0d pulses=%0d want 10/1",
               done_at, dones);
    end
    idle(2);
  endtask

  task automatic test_zero_steps;
    int done_at;
    int loads;
    int clr_at;
    done_at = -1;
    loads   = 0;
    clr_at  = -1;
    steps   = 6'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (arLoad === 1'b1) loads++;
      if (arxClr === 1'b1 && clr_at < 0) clr_at = c;
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
    tests++;
    if (done_at !== 2) begin
      fails++; $display("FAIL zero_done: got %0d want 2", done_at);
    end
    tests++;
    if (loads !== 0 || clr_at !== 1) begin
      fails++;
      $display("FAIL zero_loads: got loads=%0d clr_at=%0d want 0/1",
               loads, clr_at);
    end
    idle(2);
  endtask

  task automatic test_saturate;
    int done_at;
    int shr;
    done_at = -1;
    shr     = 0;
    steps   = 6'd63;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (stepsLeft !== 6'd36) begin
      fails++; $display("FAIL sat_load: got %0d want 36", stepsLeft);
    end
    for (int c = 1; c <= 90; c++) begin
      tick();
      if (mqSel === MQ_SHR) shr++;
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
    tests++;
    if (done_at !== 74 || shr !== 36) begin
      fails++;
      $display("FAIL sat_run: got done=%0d shr=%0d want 74/36",
               done_at, shr);
    end
    idle(2);
  endtask

  task automatic test_abort;
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    steps = 6'd8;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    tests++;
    if (arLoad !== 1'b0 || arxLoad !== 1'b0 || mqSel !== MQ_HOLD) begin
      fails++;
      $display("FAIL abort_gate: got ar=%b arx=%b mq=%0d want 0/0/3",
               arLoad, arxLoad, mqSel);
    end
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || stepsLeft !== 6'd6) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b left=%0d want 0/6",
               busy, stepsLeft);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busys++;
    end
    tests++;
    if (dones !== 0 || busys !== 0) begin
      fails++;
      $display("FAIL abort_quiet: got dones=%0d busy=%0d want 0/0",
               dones, busys);
    end
  endtask

  task automatic test_abort_start_idle;
    int busys;
    busys = 0;
    steps = 6'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy === 1'b1 || done === 1'b1) busys++;
    end
    tests++;
    if (busys !== 0) begin
      fails++; $display("FAIL abort_start: got %0d active want 0", busys);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    int d1;
    int n;
    d0    = -1;
    d1    = -1;
    n     = 0;
    steps = 6'd1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done === 1'b1) begin
        if (n == 0) d0 = c;
        if (n == 1) d1 = c;
        n++;
      end
      if (c == 9) start = 1'b0;
    end
    tests++;
    if (d0 !== 4 || d1 !== 9) begin
      fails++;
      $display("FAIL back_to_back: got %0d,%0d want 4,9", d0, d1);
    end
    idle(4);
  endtask

  task automatic test_scoreboard;
    logic        [35:0] ar;
    logic        [35:0] arx;
    logic        [35:0] br;
    logic        [35:0] mq;
    logic        [71:0] p;
    logic signed [71:0] expv;
    int                 done_at;
    done_at = -1;
    br      = 36'd5;
    ar      = 36'd0;
    arx     = 36'hFFFFFFFFF;
    mq      = -36'sd7;
    expv    = -72'sd35;
    steps   = 6'd36;
    start   = 1'b1;
    mq35    = mq[0];
    tick();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (arxClr === 1'b1) arx = '0;
      if (arLoad === 1'b1 && arSel === S_AD) begin
        if (adOp === OP_ADD) ar = ar + br;
        else if (adOp === OP_SUB) ar = ar - br;
      end
      if (arLoad === 1'b1 && arxLoad === 1'b1 &&
          arSel === S_SH && arxSel === S_SH) begin
        p = $signed({ar, arx}) >>> shCount;
        {ar, arx} = p;
      end
      if (mqSel === MQ_SHR) mq = {mq[35], mq[35:1]};
      mq35 = mq[0];
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    tests++;
    if (done_at !== 74) begin
      fails++; $display("FAIL sb_done: got %0d want 74", done_at);
    end
    tests++;
    if ({ar, arx} !== expv) begin
      fails++;
      $display("FAIL sb_product: got %h want %h", {ar, arx}, expv);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_booth_ops();
    test_zero_steps();
    test_saturate();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
